vga_square_plotter: RTL and testbench

Pixel-producer end of the frame-buffer plot interface.
- Captures X then Y positions from the switches.
- On command, emits one pixel per clock, with x, y, colour and write-enable, to draw a 4x4 square or to clear the whole 160x120 screen to black.
- Sits between the board-level key/switch decode and vga_adapter; its outputs drive the adapter's x, y, colour and plot inputs directly.

---
 rtl/vga_square_plotter.sv | 183 ++++++++++++++++++
 tb/tb_vga_square_plotter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_square_plotter.sv
// Pixel producer for the frame-buffer plot port: stores X/Y from switches, then
// streams a 4x4 square or a full-screen black clear, one registered pixel per clock.
// First pixel one cycle after the triggering event; done pulses one cycle after the last pixel.
module vga_square_plotter #(
  parameter int SQ_LOG2 = 2,
  parameter int SCR_W   = 160,
  parameter int SCR_H   = 120
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [6:0] pos_in,
  input  logic       store_pos,
  input  logic       clear_scr,
  input  logic       plot,
  input  logic [2:0] colour_in,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       write_en,
  output logic       busy,
  output logic       done
);

  localparam int          CW      = 2 * SQ_LOG2;
  localparam logic [7:0]  SCR_H8  = 8'(SCR_H);
  localparam logic [7:0]  CX_LAST = 8'(SCR_W - 1);
  localparam logic [6:0]  CY_LAST = 7'(SCR_H - 1);

  typedef enum logic [1:0] {IDLE, DRAW, CLEAR, DONE} state_t;

  state_t          state, state_nxt;
  logic            store_q, clear_q, plot_q;
  logic            ev_store, ev_clear, ev_plot;
  logic [6:0]      x_reg, y_reg;
  logic            sel;          // 0: next store loads X, 1: loads Y
  logic [2:0]      col_reg;
  logic [CW-1:0]   cnt;
  logic [7:0]      cx;
  logic [6:0]      cy;
  logic [7:0]      sq_x, sq_y;
  logic            cnt_last, clr_last;

  logic [7:0]      x_nxt;
  logic [6:0]      y_nxt;
  logic [2:0]      col_nxt;
  logic            we_nxt, busy_nxt, done_nxt;

  // One-cycle history of the level inputs for rising-edge detection
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      store_q <= 1'b0;
      clear_q <= 1'b0;
      plot_q  <= 1'b0;
    end else begin
      store_q <= store_pos;
      clear_q <= clear_scr;
      plot_q  <= plot;
    end
  end

  assign ev_store = store_pos & ~store_q;
  assign ev_clear = clear_scr & ~clear_q;
  assign ev_plot  = plot & ~plot_q;

  // Square pixel coordinates; y is kept 8 bits wide so bottom-edge clipping is visible
  assign sq_x     = {1'b0, x_reg} + {{(8-SQ_LOG2){1'b0}}, cnt[SQ_LOG2-1:0]};
  assign sq_y     = {1'b0, y_reg} + {{(8-SQ_LOG2){1'b0}}, cnt[CW-1:SQ_LOG2]};
  assign cnt_last = (cnt == {CW{1'b1}});
  assign clr_last = (cx == CX_LAST) && (cy == CY_LAST);

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; clear has priority over plot, plot over store
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ev_clear)     state_nxt = CLEAR;
        else if (ev_plot) state_nxt = DRAW;
      end
      DRAW:    if (cnt_last) state_nxt = DONE;
      CLEAR:   if (clr_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: next values of the registered pixel port for the current state
  always_comb begin
    x_nxt    = x_out;
    y_nxt    = y_out;
    col_nxt  = colour_out;
    we_nxt   = 1'b0;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state)
      DRAW: begin
        busy_nxt = 1'b1;
        x_nxt    = sq_x;
        col_nxt  = col_reg;
        if (sq_y >= SCR_H8) begin
          y_nxt  = 7'd0;
          we_nxt = 1'b0;
        end else begin
          y_nxt  = sq_y[6:0];
          we_nxt = 1'b1;
        end
      end
      CLEAR: begin
        busy_nxt = 1'b1;
        x_nxt    = cx;
        y_nxt    = cy;
        col_nxt  = 3'b000;
        we_nxt   = 1'b1;
      end
      DONE:    done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Registered pixel port; reset drops write_en immediately
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_out      <= 8'd0;
      y_out      <= 7'd0;
      colour_out <= 3'd0;
      write_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      x_out      <= x_nxt;
      y_out      <= y_nxt;
      colour_out <= col_nxt;
      write_en   <= we_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  // Position capture, colour latch and pixel counters; events outside IDLE are ignored
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_reg   <= 7'd0;
      y_reg   <= 7'd0;
      sel     <= 1'b0;
      col_reg <= 3'd0;
      cnt     <= '0;
      cx      <= 8'd0;
      cy      <= 7'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ev_clear) begin
            cx <= 8'd0;
            cy <= 7'd0;
          end else if (ev_plot) begin
            col_reg <= colour_in;
            cnt     <= '0;
          end else if (ev_store) begin
            if (!sel) x_reg <= pos_in;
            else      y_reg <= pos_in;
            sel <= ~sel;
          end
        end
        DRAW: cnt <= cnt + 1'b1;
        CLEAR: begin
          if (cx == CX_LAST) begin
            cx <= 8'd0;
            cy <= cy + 7'd1;
          end else begin
            cx <= cx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_square_plotter.sv
// Directed bench for vga_square_plotter: square draw, bottom clipping, full clear,
// event priority, store during busy and mid-draw reset, with hand-computed expectations.
module tb_vga_square_plotter;

  logic       clock;
  logic       resetn;
  logic [6:0] pos_in;
  logic       store_pos, clear_scr, plot;
  logic [2:0] colour_in;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       write_en, busy, done;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] qx[$];
  logic [6:0] qy[$];
  logic [2:0] qc[$];

  vga_square_plotter dut (
    .clock(clock), .resetn(resetn), .pos_in(pos_in), .store_pos(store_pos),
    .clear_scr(clear_scr), .plot(plot), .colour_in(colour_in),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .write_en(write_en), .busy(busy), .done(done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic do_store(input logic [6:0] p);
    @(negedge clock); pos_in = p; store_pos = 1'b1;
    @(negedge clock); store_pos = 1'b0;
  endtask

  task automatic do_plot(input logic [2:0] c);
    @(negedge clock); colour_in = c; plot = 1'b1;
    @(negedge clock); plot = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clock); clear_scr = 1'b1;
    @(negedge clock); clear_scr = 1'b0;
  endtask

  // Collect pixels at each falling edge until done appears or the budget runs out
  task automatic scan(input int budget, output int nwr, output int nbusy, output int first_c,
                      output int done_c, output int stray, output bit tmo);
    qx.delete(); qy.delete(); qc.delete();
    nwr = 0; nbusy = 0; first_c = -1; done_c = -1; stray = 0; tmo = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (write_en) begin
        if (first_c < 0) first_c = c;
        nwr++;
        qx.push_back(x_out); qy.push_back(y_out); qc.push_back(colour_out);
      end
      if (busy) nbusy++;
      if (write_en && !busy) stray++;
      if (done) begin done_c = c; tmo = 1'b0; break; end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    vectors++; if (x_out !== 8'd0) begin miscompares++; $display("FAIL rst_x: got %0d want 0", x_out); end
    vectors++; if (y_out !== 7'd0) begin miscompares++; $display("FAIL rst_y: got %0d want 0", y_out); end
    vectors++; if (colour_out !== 3'd0) begin miscompares++; $display("FAIL rst_col: got %0d want 0", colour_out); end
    vectors++; if ({write_en, busy, done} !== 3'b000) begin miscompares++; $display("FAIL rst_ctl: got %b want 000", {write_en, busy, done}); end
    @(negedge clock); resetn = 1'b1;
  endtask

  task automatic test_square();
    int nwr, nbusy, first_c, done_c, stray; bit tmo;
    do_store(7'd10); do_store(7'd20); do_plot(3'b101);
    scan(40, nwr, nbusy, first_c, done_c, stray, tmo);
    vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL sq_timeout: got %0d want 0", tmo); end
    vectors++; if (nwr !== 16) begin miscompares++; $display("FAIL sq_nwr: got %0d want 16", nwr); end
    vectors++; if (nbusy !== 16) begin miscompares++; $display("FAIL sq_busy: got %0d want 16", nbusy); end
    vectors++; if (first_c !== 1) begin miscompares++; $display("FAIL sq_first_lat: got %0d want 1", first_c); end
    vectors++; if (done_c !== 17) begin miscompares++; $display("FAIL sq_done_lat: got %0d want 17", done_c); end
    vectors++; if (stray !== 0) begin miscompares++; $display("FAIL sq_stray_we: got %0d want 0", stray); end
    for (int i = 0; i < 16; i++) begin
      if (i < qx.size()) begin
        logic [7:0] ex; logic [6:0] ey;
        ex = 8'(10 + i % 4); ey = 7'(20 + i / 4);
        vectors++;
        if (qx[i] !== ex || qy[i] !== ey || qc[i] !== 3'b101) begin
          miscompares++;
          $display("FAIL sq_pix%0d: got (%0d,%0d,%b) want (%0d,%0d,101)", i, qx[i], qy[i], qc[i], ex, ey);
        end
      end
    end
    @(negedge clock);
    vectors++; if ({done, write_en, busy} !== 3'b000) begin miscompares++; $display("FAIL sq_after_done: got %b want 000", {done, write_en, busy}); end
  endtask

  task automatic test_clip();
    int nwr, nbusy, first_c, done_c, stray; bit tmo;
    do_store(7'd127); do_store(7'd118); do_plot(3'b011);
    scan(40, nwr, nbusy, first_c, done_c, stray, tmo);
    vectors++; if (nwr !== 8) begin miscompares++; $display("FAIL clip_nwr: got %0d want 8", nwr); end
    vectors++; if (nbusy !== 16) begin miscompares++; $display("FAIL clip_busy: got %0d want 16", nbusy); end
    vectors++; if (done_c !== 17) begin miscompares++; $display("FAIL clip_done_lat: got %0d want 17", done_c); end
    for (int i = 0; i < 8; i++) begin
      if (i < qx.size()) begin
        logic [7:0] ex; logic [6:0] ey;
        ex = 8'(127 + i % 4); ey = 7'(118 + i / 4);
        vectors++;
        if (qx[i] !== ex || qy[i] !== ey || qc[i] !== 3'b011) begin
          miscompares++;
          $display("FAIL clip_pix%0d: got (%0d,%0d,%b) want (%0d,%0d,011)", i, qx[i], qy[i], qc[i], ex, ey);
        end
      end
    end
    // last cycle was the suppressed (130,121) pixel, so y was driven to 0 and held
    vectors++; if (x_out !== 8'd130 || y_out !== 7'd0) begin miscompares++; $display("FAIL clip_hold: got (%0d,%0d) want (130,0)", x_out, y_out); end
  endtask

  task automatic test_clear();
    int nwr, nbusy, first_c, done_c, stray, errs; bit tmo;
    do_clear();
    scan(19300, nwr, nbusy, first_c, done_c, stray, tmo);
    vectors++; if (nwr !== 19200) begin miscompares++; $display("FAIL clr_nwr: got %0d want 19200", nwr); end
    vectors++; if (nbusy !== 19200) begin miscompares++; $display("FAIL clr_busy: got %0d want 19200", nbusy); end
    vectors++; if (first_c !== 1) begin miscompares++; $display("FAIL clr_first_lat: got %0d want 1", first_c); end
    vectors++; if (done_c !== 19201) begin miscompares++; $display("FAIL clr_done_lat: got %0d want 19201", done_c); end
    if (qx.size() == 19200) begin
      vectors++; if (qx[0] !== 8'd0 || qy[0] !== 7'd0) begin miscompares++; $display("FAIL clr_first: got (%0d,%0d) want (0,0)", qx[0], qy[0]); end
      vectors++; if (qx[159] !== 8'd159 || qy[159] !== 7'd0) begin miscompares++; $display("FAIL clr_row0_end: got (%0d,%0d) want (159,0)", qx[159], qy[159]); end
      vectors++; if (qx[160] !== 8'd0 || qy[160] !== 7'd1) begin miscompares++; $display("FAIL clr_row1_start: got (%0d,%0d) want (0,1)", qx[160], qy[160]); end
      vectors++; if (qx[19199] !== 8'd159 || qy[19199] !== 7'd119) begin miscompares++; $display("FAIL clr_last: got (%0d,%0d) want (159,119)", qx[19199], qy[19199]); end
      errs = 0;
      for (int i = 0; i < 19200; i++)
        if (qx[i] !== 8'(i % 160) || qy[i] !== 7'(i / 160) || qc[i] !== 3'b000) errs++;
      vectors++; if (errs !== 0) begin miscompares++; $display("FAIL clr_raster: got %0d bad pixels want 0", errs); end
    end
  endtask

  task automatic test_priority_hold();
    int nwr, nbusy, first_c, done_c, stray, coloured, extra; bit tmo;
    @(negedge clock); colour_in = 3'b111; clear_scr = 1'b1; plot = 1'b1;
    @(negedge clock); clear_scr = 1'b0;
    scan(19300, nwr, nbusy, first_c, done_c, stray, tmo);
    vectors++; if (nwr !== 19200) begin miscompares++; $display("FAIL prio_nwr: got %0d want 19200", nwr); end
    coloured = 0;
    foreach (qc[i]) if (qc[i] !== 3'b000) coloured++;
    vectors++; if (coloured !== 0) begin miscompares++; $display("FAIL prio_colour: got %0d coloured pixels want 0", coloured); end
    extra = 0;
    repeat (6) begin @(negedge clock); if (write_en || busy) extra++; end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL prio_retrigger: got %0d active cycles want 0", extra); end
    plot = 1'b0;
  endtask

  task automatic test_store_busy();
    int nwr, nbusy, first_c, done_c, stray; bit tmo;
    do_clear();
    repeat (3) @(negedge clock);
    pos_in = 7'd50; store_pos = 1'b1;
    @(negedge clock); store_pos = 1'b0;
    scan(19300, nwr, nbusy, first_c, done_c, stray, tmo);
    vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL sb_timeout: got %0d want 0", tmo); end
    do_store(7'd30); do_store(7'd40); do_plot(3'b001);
    scan(40, nwr, nbusy, first_c, done_c, stray, tmo);
    vectors++; if (nwr !== 16) begin miscompares++; $display("FAIL sb_nwr: got %0d want 16", nwr); end
    if (qx.size() == 16) begin
      vectors++; if (qx[0] !== 8'd30 || qy[0] !== 7'd40) begin miscompares++; $display("FAIL sb_first: got (%0d,%0d) want (30,40)", qx[0], qy[0]); end
      vectors++; if (qx[15] !== 8'd33 || qy[15] !== 7'd43 || qc[15] !== 3'b001) begin miscompares++; $display("FAIL sb_last: got (%0d,%0d,%b) want (33,43,001)", qx[15], qy[15], qc[15]); end
    end
  endtask

  task automatic test_reset_mid();
    int nwr, nbusy, first_c, done_c, stray, n, active; bit tmo;
    do_store(7'd5); do_store(7'd6); do_store(7'd7);   // X=7, Y=6, sel left at Y
    do_plot(3'b010);
    n = 0;
    for (int c = 0; c < 30; c++) begin
      if (write_en) n++;
      if (n == 5) break;
      @(negedge clock);
    end
    vectors++; if (n !== 5) begin miscompares++; $display("FAIL rm_reach: got %0d pixels want 5", n); end
    vectors++; if (x_out !== 8'd7 || y_out !== 7'd7) begin miscompares++; $display("FAIL rm_pix5: got (%0d,%0d) want (7,7)", x_out, y_out); end
    resetn = 1'b0;
    #1;
    vectors++; if ({write_en, busy, done} !== 3'b000) begin miscompares++; $display("FAIL rm_async: got %b want 000", {write_en, busy, done}); end
    vectors++; if (x_out !== 8'd0 || y_out !== 7'd0) begin miscompares++; $display("FAIL rm_xy: got (%0d,%0d) want (0,0)", x_out, y_out); end
    @(negedge clock); resetn = 1'b1;
    active = 0;
    repeat (4) begin @(negedge clock); if (write_en || busy) active++; end
    vectors++; if (active !== 0) begin miscompares++; $display("FAIL rm_idle: got %0d active cycles want 0", active); end
    do_plot(3'b100);
    scan(40, nwr, nbusy, first_c, done_c, stray, tmo);
    vectors++; if (nwr !== 16) begin miscompares++; $display("FAIL rm_nwr: got %0d want 16", nwr); end
    if (qx.size() > 0) begin
      vectors++; if (qx[0] !== 8'd0 || qy[0] !== 7'd0 || qc[0] !== 3'b100) begin miscompares++; $display("FAIL rm_regs_zero: got (%0d,%0d,%b) want (0,0,100)", qx[0], qy[0], qc[0]); end
    end
    do_store(7'd70); do_store(7'd9); do_plot(3'b110);
    scan(40, nwr, nbusy, first_c, done_c, stray, tmo);
    if (qx.size() > 0) begin
      vectors++; if (qx[0] !== 8'd70 || qy[0] !== 7'd9) begin miscompares++; $display("FAIL rm_sel_x: got (%0d,%0d) want (70,9)", qx[0], qy[0]); end
    end else begin
      vectors++; miscompares++; $display("FAIL rm_sel_x: got 0 pixels want 16");
    end
  endtask

  initial begin
    resetn = 1'b0; pos_in = 7'd0; store_pos = 1'b0; clear_scr = 1'b0; plot = 1'b0; colour_in = 3'd0;
    test_reset();
    test_square();
    test_clip();
    test_clear();
    test_priority_hold();
    test_store_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
